// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - multi-port register file with issue/writeback scoreboard
//
// Purpose: integer register file that tracks outstanding producers per register.
// Decode claims destinations through the issue port, and writeback ports clear those
// claims while writing data. Reads report a per-port busy flag so decode can stall
// on RAW hazards. An optional same-cycle writeback bypass feeds the reads and the
// issue check.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   stackptr         reset value loaded into register SP_INDEX
//   rd_addr/rd_data  NUM_READ combinational read ports (flattened slices)
//   rd_busy          per read port: source register has an outstanding producer
//   issue_valid/rd   decode claim of a destination register
//   issue_ready      the claim can be accepted this cycle
//   flush            clears every busy bit (pipeline squash)
//   wr_en/addr/data  NUM_WRITE writeback ports (flattened slices)
//   write_complete   wr_en registered, one bit per writeback port
//   busy_vec         current scoreboard state
//   hazard           any rd_busy, or a refused issue
module scoreboard_regfile #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int SP_INDEX   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          stackptr,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           issue_valid,
    input  logic [ADDR_WIDTH-1:0]          issue_rd,
    output logic                           issue_ready,
    input  logic                           flush,
    input  logic [NUM_WRITE-1:0]           wr_en,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_WRITE-1:0]           write_complete,
    output logic [2**ADDR_WIDTH-1:0]       busy_vec,
    output logic                           hazard
);

    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam bit BYP   = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic [NUM_WRITE-1:0]  wc_q;

    logic [ADDR_WIDTH-1:0] wa     [NUM_WRITE];
    logic [DATA_WIDTH-1:0] wd     [NUM_WRITE];
    logic [ADDR_WIDTH-1:0] ra     [NUM_READ];
    logic                  rd_hit [NUM_READ];
    logic [DATA_WIDTH-1:0] rd_fwd [NUM_READ];
    logic                  issue_wr_hit;
    logic                  issue_acc;

    // Unpack the writeback port slices once so the rest of the logic stays readable.
    always_comb begin
        for (int j = 0; j < NUM_WRITE; j++) begin
            wa[j] = wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            wd[j] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Read ports. Writes are scanned in ascending port order so the highest
    // matching port is the one left in rd_fwd.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            ra[i]     = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rd_hit[i] = 1'b0;
            rd_fwd[i] = '0;
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wr_en[j] && (wa[j] == ra[i]) && (ra[i] != '0)) begin
                    rd_hit[i] = 1'b1;
                    rd_fwd[i] = wd[j];
                end
            end
            if (ra[i] == '0) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                rd_busy[i]                          = 1'b0;
            end else if (BYP && rd_hit[i]) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_fwd[i];
                rd_busy[i]                          = 1'b0;
            end else begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra[i]];
                rd_busy[i]                          = busy_q[ra[i]];
            end
        end
    end

    // Issue check: a busy destination may still be claimed when its producer
    // writes back in this same cycle (bypass only), since set beats clear below.
    always_comb begin
        issue_wr_hit = 1'b0;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (wr_en[j] && (wa[j] == issue_rd)) begin
                issue_wr_hit = 1'b1;
            end
        end
        issue_ready = !flush && ((issue_rd == '0) || !busy_q[issue_rd] ||
                                 (BYP && issue_wr_hit));
        issue_acc   = issue_valid && issue_ready && !flush;
        hazard      = (|rd_busy) || (issue_valid && !issue_ready);
    end

    // Next state: writeback clears, then issue sets, then flush wipes everything.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NREGS; k++) begin
            regs_d[k] = regs_q[k];
        end
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (wr_en[j]) begin
                busy_d[wa[j]] = 1'b0;
                if (wa[j] != '0) begin
                    regs_d[wa[j]] = wd[j];
                end
            end
        end
        if (issue_acc && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= (k == SP_INDEX) ? stackptr : '0;
            end
            busy_q <= '0;
            wc_q   <= '0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            busy_q <= busy_d;
            wc_q   <= wr_en;
        end
    end

    assign write_complete = wc_q;
    assign busy_vec       = busy_q;

endmodule

// File: doc/scoreboard_regfile.md
# scoreboard_regfile

Parametrised multi-port integer register file with a built-in scoreboard for the in-order pipeline's decode/writeback boundary. Decode issues destination registers, marking them busy; writeback ports clear them and write data. Reads report per-port busy so decode can stall on RAW hazards. An optional same-cycle write-to-read bypass is provided. Issue is refused on WAW conflicts.

## Interface
- ADDR_WIDTH, 5, register index width; NREGS = 2**ADDR_WIDTH
- DATA_WIDTH, 64, register width
- NUM_READ, 2, number of read ports
- NUM_WRITE, 2, number of writeback ports
- SP_INDEX, 2, register loaded from stackptr at reset
- BYPASS, 1, 1 = same-cycle writeback forwarded to reads/issue check
- clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
- reset  in  1  synchronous, active-high
- stackptr  in  DATA_WIDTH  reset value of register SP_INDEX
- rd_addr  in  NUM_READ*ADDR_WIDTH  read addresses, port i at slice i
- rd_data  out  NUM_READ*DATA_WIDTH  read data, combinational
- rd_busy  out  NUM_READ  port i source has outstanding producer
- issue_valid  in  1  decode requests to claim issue_rd
- issue_rd  in  ADDR_WIDTH  destination being claimed
- issue_ready  out  1  claim can be accepted this cycle
- flush  in  1  clear all busy bits (pipeline squash)
- wr_en  in  NUM_WRITE  writeback valid per port
- wr_addr  in  NUM_WRITE*ADDR_WIDTH  writeback addresses
- wr_data  in  NUM_WRITE*DATA_WIDTH  writeback data
- write_complete  out  NUM_WRITE  registered ack, one per port
- busy_vec  out  NREGS  current scoreboard state
- hazard  out  1  any rd_busy, or issue_valid && !issue_ready

## Operation
- Storage: NREGS x DATA_WIDTH regs plus NREGS busy bits. Register 0 reads 0, is never written, and is never busy.
- Write: on each clk, each port with wr_en and nonzero wr_addr writes wr_data. Two ports hitting the same address: the highest-index port wins for data. Every busy bit addressed by an enabled port is cleared.
- Issue: accepted = issue_valid && issue_ready && !flush. An accepted issue sets busy[issue_rd] when issue_rd != 0.
- issue_rd == 0 is always accepted with no state change.
- issue_ready = !flush && (issue_rd == 0 || !busy[issue_rd] || (BYPASS && some wr_en port targets issue_rd)).
- Simultaneous set (issue) and clear (writeback) on the same register: set wins, so busy = 1 afterward and the data is still written.
- Flush: clears all busy bits next cycle and has priority over both issue and clear. Data writes still happen.
- Read port i with address a:
  - BYPASS=1 and an enabled write to a≠0 this cycle: rd_data is that port's wr_data (highest port wins) and rd_busy = 0.
  - Otherwise rd_data = reg[a] and rd_busy = busy[a].
  - Reads of address 0 give 0 and not busy.
  - Unlike the legacy file, rd_data is never zeroed when busy; consumers must gate on rd_busy.
- write_complete[j] is wr_en[j] registered. It is asserted even for wr_addr 0.

## Timing
- Reads and issue_ready are combinational from current state plus same-cycle writes.
- A write or busy change is visible through the non-bypass path one cycle later.
- write_complete latency: 1 cycle after wr_en.
- A busy bit set by an issue at cycle N is first visible to reads at N+1.
- Reset, taking priority over all inputs, at the clk edge:
  - register SP_INDEX = stackptr; all other registers = 0
  - busy_vec = 0, write_complete = 0
  - so rd_busy = 0, hazard = 0, and issue_ready = 1 after reset
- Reset mid-operation discards all outstanding busy claims and pending writes in that cycle.

## Test plan
- Reset with stackptr=0x8000_0000 -> read x2 = 0x8000_0000 and x5 = 0, busy_vec = 0, write_complete = 0.
- Issue x5, then read x5 next cycle -> rd_busy = 1, hazard = 1. Write x5=0xDEAD -> same cycle rd_data = 0xDEAD with rd_busy = 0 (BYPASS=1); next cycle busy[5] = 0 and write_complete = 1.
- Issue x7 while x7 is busy with no writeback -> issue_ready = 0 and busy unchanged. Repeat with a same-cycle write to x7 -> accepted, and busy[7] = 1 afterward.
- Ports 0 and 1 both write x9 (0x11, 0x22) -> x9 = 0x22 and busy[9] = 0.
- Write x0 = 0xFFFF and issue x0 -> x0 reads 0, busy_vec[0] = 0, write_complete[0] = 1 the next cycle.
- Set busy on x3, x4, then flush together with issue x6 -> busy_vec = 0 next cycle, issue_ready = 0 during flush, and x6 is not busy.
